// File: rtl/fe_stage_bpred_pkg.sv
// Shared widths, reset values and the FE->DE latch layout for the fetch stage.
package fe_stage_bpred_pkg;

    localparam int DBITS        = 32;
    localparam int INSTBITS     = 32;
    localparam int PTINDEXBITS  = 8;
    localparam int BTBINDEXBITS = 4;
    localparam int TAGBITS      = DBITS - BTBINDEXBITS - 2;
    localparam int PT_ENTRIES   = 1 << PTINDEXBITS;
    localparam int BTB_ENTRIES  = 1 << BTBINDEXBITS;

    localparam logic [DBITS-1:0] STARTPC = 32'h0000_0100;
    // Counters start weakly not-taken.
    localparam logic [1:0]       PT_INIT = 2'b01;

    // FE latch, fields in the same order as the output ports.
    typedef struct packed {
        logic                    valid;
        logic [INSTBITS-1:0]     inst;
        logic [DBITS-1:0]        pc;
        logic [DBITS-1:0]        pcplus;
        logic [DBITS-1:0]        inst_count;
        logic                    btb_hit;
        logic                    pred_taken;
        logic [DBITS-1:0]        pred_target;
        logic [PTINDEXBITS-1:0]  pt_idx;
        logic [BTBINDEXBITS-1:0] btb_idx;
    } fe_latch_t;

    localparam int FE_LATCH_BITS = $bits(fe_latch_t);

    // 2-bit saturating counter step.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/fe_stage_bpred_tables.sv
// Gshare pattern table, global history register and direct-mapped BTB.
// One combinational lookup port and one update port; updates land at the
// clock edge, so a same-cycle lookup always sees the pre-update contents.
module bpred_tables
    import fe_stage_bpred_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        lookup_pc,
    output logic                    btb_hit,
    output logic                    pred_taken,
    output logic [DBITS-1:0]        pred_target,
    output logic [PTINDEXBITS-1:0]  pt_idx,
    output logic [BTBINDEXBITS-1:0] btb_idx,
    output logic [PTINDEXBITS-1:0]  bhr,
    input  logic                    upd_valid,
    input  logic [DBITS-1:0]        upd_pc,
    input  logic                    upd_taken,
    input  logic [DBITS-1:0]        upd_target,
    input  logic [PTINDEXBITS-1:0]  upd_pt_idx
);

    logic [PTINDEXBITS-1:0]  bhr_q;
    logic [1:0]              pt_q         [PT_ENTRIES];
    logic                    btb_valid_q  [BTB_ENTRIES];
    logic [TAGBITS-1:0]      btb_tag_q    [BTB_ENTRIES];
    logic [DBITS-1:0]        btb_target_q [BTB_ENTRIES];

    logic [BTBINDEXBITS-1:0] upd_btb_idx;
    logic                    unused_upd_pc_bits;

    assign upd_btb_idx        = upd_pc[BTBINDEXBITS+1:2];
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    // Lookup: history-hashed PT index, PC-indexed BTB, predicted next PC.
    assign pt_idx      = lookup_pc[PTINDEXBITS+1:2] ^ bhr_q;
    assign btb_idx     = lookup_pc[BTBINDEXBITS+1:2];
    assign btb_hit     = btb_valid_q[btb_idx] &&
                         (btb_tag_q[btb_idx] == lookup_pc[DBITS-1:BTBINDEXBITS+2]);
    assign pred_taken  = btb_hit && pt_q[pt_idx][1];
    assign pred_target = pred_taken ? btb_target_q[btb_idx] : lookup_pc + DBITS'(4);
    assign bhr         = bhr_q;

    // History only advances on resolved branches (non-speculative).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bhr_q <= '0;
        end else if (upd_valid) begin
            bhr_q <= {bhr_q[PTINDEXBITS-2:0], upd_taken};
        end
    end

    // Pattern table: saturating counter train on every resolution.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PT_ENTRIES; i++) begin
                pt_q[i] <= PT_INIT;
            end
        end else if (upd_valid) begin
            pt_q[upd_pt_idx] <= sat_update(pt_q[upd_pt_idx], upd_taken);
        end
    end

    // BTB: only taken branches allocate or refresh an entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_valid_q[upd_btb_idx]  <= 1'b1;
            btb_tag_q[upd_btb_idx]    <= upd_pc[DBITS-1:BTBINDEXBITS+2];
            btb_target_q[upd_btb_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/fe_stage_bpred.sv
// Fetch stage: owns the PC and the FE->DE latch, predicts with bpred_tables.
// Handshake: fe_valid is the latch's valid and !stall_de is DE's ready; while
// stall_de is high the latch contents and the PC hold unchanged. A redirect
// overrides a stall and drops a bubble into the latch.
module fe_stage_bpred
    import fe_stage_bpred_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    output logic [DBITS-1:0]        imem_addr,
    input  logic [INSTBITS-1:0]     imem_rdata,
    input  logic                    stall_de,
    input  logic                    redirect_valid,
    input  logic [DBITS-1:0]        redirect_pc,
    input  logic                    upd_valid,
    input  logic [DBITS-1:0]        upd_pc,
    input  logic                    upd_taken,
    input  logic [DBITS-1:0]        upd_target,
    input  logic [PTINDEXBITS-1:0]  upd_pt_idx,
    output logic                    fe_valid,
    output logic [INSTBITS-1:0]     fe_inst,
    output logic [DBITS-1:0]        fe_pc,
    output logic [DBITS-1:0]        fe_pcplus,
    output logic [DBITS-1:0]        fe_inst_count,
    output logic                    fe_btb_hit,
    output logic                    fe_pred_taken,
    output logic [DBITS-1:0]        fe_pred_target,
    output logic [PTINDEXBITS-1:0]  fe_pt_idx,
    output logic [BTBINDEXBITS-1:0] fe_btb_idx,
    output logic [PTINDEXBITS-1:0]  bhr_out
);

    logic [DBITS-1:0]        pc_q;
    logic [DBITS-1:0]        count_q;
    fe_latch_t               fe_q;
    fe_latch_t               fe_d;

    logic                    lk_hit;
    logic                    lk_taken;
    logic [DBITS-1:0]        lk_next;
    logic [PTINDEXBITS-1:0]  lk_pt_idx;
    logic [BTBINDEXBITS-1:0] lk_btb_idx;

    bpred_tables u_tables (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc_q),
        .btb_hit     (lk_hit),
        .pred_taken  (lk_taken),
        .pred_target (lk_next),
        .pt_idx      (lk_pt_idx),
        .btb_idx     (lk_btb_idx),
        .bhr         (bhr_out),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_pt_idx  (upd_pt_idx)
    );

    assign imem_addr = pc_q;

    // Assemble the latch contents for the instruction fetched this cycle.
    always_comb begin
        fe_d             = '0;
        fe_d.valid       = 1'b1;
        fe_d.inst        = imem_rdata;
        fe_d.pc          = pc_q;
        fe_d.pcplus      = pc_q + DBITS'(4);
        fe_d.inst_count  = count_q + DBITS'(1);
        fe_d.btb_hit     = lk_hit;
        fe_d.pred_taken  = lk_taken;
        fe_d.pred_target = lk_next;
        fe_d.pt_idx      = lk_pt_idx;
        fe_d.btb_idx     = lk_btb_idx;
    end

    // PC: redirect wins, stall holds, otherwise follow the prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= STARTPC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (!stall_de) begin
            pc_q <= lk_next;
        end
    end

    // FE latch: bubble on redirect, hold on stall, load on a normal fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fe_q <= '0;
        end else if (redirect_valid) begin
            fe_q <= '0;
        end else if (!stall_de) begin
            fe_q <= fe_d;
        end
    end

    // Fetch counter survives bubbles; it only advances on a real fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (!redirect_valid && !stall_de) begin
            count_q <= count_q + DBITS'(1);
        end
    end

    assign fe_valid       = fe_q.valid;
    assign fe_inst        = fe_q.inst;
    assign fe_pc          = fe_q.pc;
    assign fe_pcplus      = fe_q.pcplus;
    assign fe_inst_count  = fe_q.inst_count;
    assign fe_btb_hit     = fe_q.btb_hit;
    assign fe_pred_taken  = fe_q.pred_taken;
    assign fe_pred_target = fe_q.pred_target;
    assign fe_pt_idx      = fe_q.pt_idx;
    assign fe_btb_idx     = fe_q.btb_idx;

endmodule

// File: tb/tb_fe_stage_bpred.sv
// Bench for fe_stage_bpred: directed scenarios then random traffic, all
// checked against a cycle-level behavioural model of the fetch stage.
module tb_fe_stage_bpred;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_de;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_pt_idx;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic [31:0] fe_inst_count;
    logic        fe_btb_hit;
    logic        fe_pred_taken;
    logic [31:0] fe_pred_target;
    logic [7:0]  fe_pt_idx;
    logic [3:0]  fe_btb_idx;
    logic [7:0]  bhr_out;

    fe_stage_bpred dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall_de       (stall_de),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pt_idx     (upd_pt_idx),
        .fe_valid       (fe_valid),
        .fe_inst        (fe_inst),
        .fe_pc          (fe_pc),
        .fe_pcplus      (fe_pcplus),
        .fe_inst_count  (fe_inst_count),
        .fe_btb_hit     (fe_btb_hit),
        .fe_pred_taken  (fe_pred_taken),
        .fe_pred_target (fe_pred_target),
        .fe_pt_idx      (fe_pt_idx),
        .fe_btb_idx     (fe_btb_idx),
        .bhr_out        (bhr_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory: a fixed address-dependent pattern.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction
    assign imem_rdata = imem_word(imem_addr);

    // ---------------- scoreboard ----------------
    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [7:0]  m_bhr;
    int          m_pt    [256];
    bit          m_bv    [16];
    logic [31:0] m_btag  [16];
    logic [31:0] m_btgt  [16];

    logic        e_valid;
    logic [31:0] e_inst, e_pc, e_pcplus, e_cnt, e_tgt;
    logic        e_hit, e_taken;
    logic [7:0]  e_ptidx;
    logic [3:0]  e_bidx;

    task automatic clear_latch();
        e_valid = 0; e_inst = 0; e_pc = 0; e_pcplus = 0; e_cnt = 0;
        e_hit = 0; e_taken = 0; e_tgt = 0; e_ptidx = 0; e_bidx = 0;
    endtask

    task automatic model_reset();
        m_pc  = 32'h100;
        m_cnt = 0;
        m_bhr = 0;
        for (int i = 0; i < 256; i++) m_pt[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
        end
        clear_latch();
    endtask

    function automatic logic [7:0] bhr_after(input logic [7:0] b, input int n, input bit t);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], t};
        return r;
    endfunction

    task automatic compare_all();
        check("imem_addr",      imem_addr,      m_pc);
        check("fe_valid",       fe_valid,       e_valid);
        check("fe_inst",        fe_inst,        e_inst);
        check("fe_pc",          fe_pc,          e_pc);
        check("fe_pcplus",      fe_pcplus,      e_pcplus);
        check("fe_inst_count",  fe_inst_count,  e_cnt);
        check("fe_btb_hit",     fe_btb_hit,     e_hit);
        check("fe_pred_taken",  fe_pred_taken,  e_taken);
        check("fe_pred_target", fe_pred_target, e_tgt);
        check("fe_pt_idx",      fe_pt_idx,      e_ptidx);
        check("fe_btb_idx",     fe_btb_idx,     e_bidx);
        check("bhr_out",        bhr_out,        m_bhr);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: predict from the model, let the edge happen, advance the model, compare.
    task automatic step();
        int          li, bi, ui;
        bit          hit, taken;
        logic [31:0] nxt;
        li    = int'((m_pc >> 2) & 32'hFF) ^ int'(m_bhr);
        bi    = int'((m_pc >> 2) & 32'hF);
        hit   = m_bv[bi] && (m_btag[bi] == (m_pc >> 6));
        taken = hit && (m_pt[li] >= 2);
        nxt   = taken ? m_btgt[bi] : m_pc + 32'd4;
        @(posedge clk);
        if (redirect_valid) begin
            m_pc = redirect_pc;
            clear_latch();
        end else if (!stall_de) begin
            m_cnt    = m_cnt + 1;
            e_valid  = 1;
            e_inst   = imem_word(m_pc);
            e_pc     = m_pc;
            e_pcplus = m_pc + 32'd4;
            e_cnt    = m_cnt;
            e_hit    = hit;
            e_taken  = taken;
            e_tgt    = nxt;
            e_ptidx  = 8'(li);
            e_bidx   = 4'(bi);
            m_pc     = nxt;
        end
        if (upd_valid) begin
            ui = int'(upd_pt_idx);
            if (upd_taken) m_pt[ui] = (m_pt[ui] == 3) ? 3 : m_pt[ui] + 1;
            else           m_pt[ui] = (m_pt[ui] == 0) ? 0 : m_pt[ui] - 1;
            m_bhr = {m_bhr[6:0], upd_taken};
            if (upd_taken) begin
                bi = int'((upd_pc >> 2) & 32'hF);
                m_bv[bi]   = 1;
                m_btag[bi] = upd_pc >> 6;
                m_btgt[bi] = upd_target;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        stall_de = 0; redirect_valid = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_pt_idx = 0;
    endtask

    // Resolve one branch while DE stalls, so fetch does not move.
    task automatic upd_step(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                            input logic [7:0] idx);
        stall_de = 1; upd_valid = 1; upd_pc = pc; upd_taken = t;
        upd_target = tgt; upd_pt_idx = idx;
        step();
        upd_valid = 0; stall_de = 0;
    endtask

    // Redirect to pc; after this returns the FE latch holds the fetch of pc.
    task automatic fetch_at(input logic [31:0] pc);
        redirect_valid = 1; redirect_pc = pc; stall_de = 0;
        step();
        redirect_valid = 0;
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    logic [7:0]  x_a, b_a;
    logic [31:0] hold_pc, hold_inst, hold_cnt;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_fe_valid", fe_valid, 1'b0);
        @(negedge clk);
        reset = 1;

        // Sequential fetch from the reset PC with nothing predicted.
        step(); check("t1_pc0", fe_pc, 32'h100); check("t1_cnt0", fe_inst_count, 32'd1);
        step(); check("t1_pc1", fe_pc, 32'h104);
        step(); check("t1_pc2", fe_pc, 32'h108); check("t1_pred", fe_pred_taken, 1'b0);

        // Train a taken branch at 0x120 -> 0x200 on the index fetch will use.
        x_a = 8'h48 ^ bhr_after(m_bhr, 3, 1'b1);
        repeat (3) upd_step(32'h120, 1'b1, 32'h200, x_a);
        fetch_at(32'h120);
        check("t2_hit", fe_btb_hit, 1'b1);
        check("t2_taken", fe_pred_taken, 1'b1);
        check("t2_tgt", fe_pred_target, 32'h200);
        step();
        check("t2_next_pc", fe_pc, 32'h200);

        // Redirect beats a simultaneous stall.
        redirect_valid = 1; redirect_pc = 32'h300; stall_de = 1;
        step();
        check("t3_bubble", fe_valid, 1'b0);
        redirect_valid = 0; stall_de = 0;
        step();
        check("t3_pc", fe_pc, 32'h300);

        // Stall holds the latch while resolutions keep shifting history.
        hold_pc = e_pc; hold_inst = e_inst; hold_cnt = e_cnt;
        for (int i = 0; i < 3; i++) begin
            upd_step(32'h184, i[0], 32'h0, 8'h10);
            check("t4_pc_hold", fe_pc, hold_pc);
            check("t4_inst_hold", fe_inst, hold_inst);
            check("t4_cnt_hold", fe_inst_count, hold_cnt);
        end

        // Saturation at the top: five taken leave the counter strongly taken.
        x_a = 8'h48 ^ bhr_after(m_bhr, 5, 1'b1);
        repeat (5) upd_step(32'h120, 1'b1, 32'h200, x_a);
        b_a = m_bhr;
        fetch_at(32'h120);
        check("t5_top_taken", fe_pred_taken, 1'b1);
        // Saturation at the bottom: five not-taken then one taken must read 1.
        repeat (5) upd_step(32'h120, 1'b0, 32'h0, x_a);
        upd_step(32'h120, 1'b1, 32'h200, x_a);
        for (int k = 7; k >= 0; k--) upd_step(32'h4000_003C, b_a[k], 32'h500, x_a ^ 8'h80);
        fetch_at(32'h120);
        check("t5_bhr_restored", bhr_out, b_a);
        check("t5_bottom_nt", fe_pred_taken, 1'b0);

        // Random traffic over a small PC window so tables alias and hit.
        for (int n = 0; n < 400; n++) begin
            stall_de       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = {22'h0, 8'($urandom_range(8'h40, 8'h7F)), 2'b00};
            upd_valid      = ($urandom_range(0, 2) == 0);
            upd_pc         = {22'h0, 8'($urandom_range(8'h40, 8'h7F)), 2'b00};
            upd_taken      = 1'($urandom_range(0, 1));
            upd_target     = {22'h0, 8'($urandom_range(8'h40, 8'h7F)), 2'b00};
            upd_pt_idx     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'((upd_pc >> 2) ^ 32'(m_bhr));
            step();
        end

        // Asynchronous reset mid-stream with an update in flight.
        idle_inputs();
        upd_valid = 1; upd_pc = 32'h124; upd_taken = 1; upd_target = 32'h380; upd_pt_idx = 8'h33;
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        model_reset();
        compare_all();
        check("t6_pc_restart", imem_addr, 32'h100);
        check("t6_count", fe_inst_count, 32'h0);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        fetch_at(32'h120);
        check("t6_btb_miss", fe_btb_hit, 1'b0);
        fetch_at(32'h124);
        check("t6_inflight_dropped", fe_btb_hit, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
